// File: rtl/stream_join_buf.sv
// Joins N_INP valid/ready input lanes into one output beat.
// One slot per lane; a lane stalls until every lane has data.
module stream_join_buf #(
    parameter int N_INP      = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_INP-1:0]            valid_i,
    output logic [N_INP-1:0]            ready_o,
    input  logic [N_INP*DATA_WIDTH-1:0] data_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [N_INP*DATA_WIDTH-1:0] data_o
);

    logic [N_INP-1:0]                 r_full;
    logic [N_INP-1:0][DATA_WIDTH-1:0] r_data;
    logic                             w_pop;
    logic [N_INP-1:0]                 w_cap;

    assign valid_o = &r_full;
    assign w_pop   = valid_o & ready_i;
    assign data_o  = r_data;

    // A full slot reopens only in the cycle its current beat leaves.
    assign ready_o = rst_ni ? (~r_full | {N_INP{w_pop}}) : '0;
    assign w_cap   = valid_i & ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_full <= '0;
            r_data <= '0;
        end else begin
            for (int i = 0; i < N_INP; i++) begin
                if (w_cap[i]) begin
                    r_full[i] <= 1'b1;
                    r_data[i] <= data_i[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (w_pop) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_join_buf.sv
// Bench for stream_join_buf (3 lanes x 8 bits): directed table,
// corner sequences and random traffic against a per-lane queue model.
module tb_stream_join_buf;

    localparam int N = 3;
    localparam int W = 8;

    logic           clk;
    logic           rst_ni;
    logic [N-1:0]   valid_i;
    logic [N-1:0]   ready_o;
    logic [N*W-1:0] data_i;
    logic           valid_o;
    logic           ready_i;
    logic [N*W-1:0] data_o;

    stream_join_buf #(.N_INP(N), .DATA_WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: each lane is a queue of accepted beats awaiting the join.
    logic [W-1:0] mq [N][$];

    logic           s_vo;
    logic [N-1:0]   s_ro;
    logic [N*W-1:0] s_do;

    typedef struct {
        logic           rs;
        logic [N-1:0]   v;
        logic [N*W-1:0] d;
        logic           r;
        logic           evo;
        logic [N-1:0]   ero;
        logic           cd;
        logic [N*W-1:0] edo;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic r, input logic rs, input logic en);
        logic           e_vo;
        logic [N-1:0]   e_ro;
        logic [N*W-1:0] e_do;
        logic [N-1:0]   cap;
        @(negedge clk);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        rst_ni  = rs;
        #1;
        s_vo = valid_o;
        s_ro = ready_o;
        s_do = data_o;
        e_vo = 1'b1;
        e_do = '0;
        for (int i = 0; i < N; i++) begin
            if (mq[i].size() == 0) e_vo = 1'b0;
            else e_do[i*W +: W] = mq[i][0];
        end
        for (int i = 0; i < N; i++)
            e_ro[i] = rs && (mq[i].size() == 0 || (e_vo && r));
        if (en) begin
            chk("valid_o", 32'(s_vo), 32'(e_vo));
            chk("ready_o", 32'(s_ro), 32'(e_ro));
            if (e_vo) chk("data_o", 32'(s_do), 32'(e_do));
        end
        cap = v & e_ro;
        @(posedge clk);
        if (!rs) begin
            for (int i = 0; i < N; i++) mq[i].delete();
        end else begin
            if (e_vo && r)
                for (int i = 0; i < N; i++) void'(mq[i].pop_front());
            for (int i = 0; i < N; i++)
                if (cap[i]) mq[i].push_back(d[i*W +: W]);
        end
    endtask

    initial begin
        int pops;
        logic           p_hold;
        logic           p_vo;
        logic [N*W-1:0] p_do;
        logic [N-1:0]   rv;
        logic           rr;
        logic           rrs;

        // rs, v, d, ready_i, exp valid_o, exp ready_o, check data, exp data
        tbl[0]  = '{1'b1, 3'b000, 24'h000000, 1'b0, 1'b0, 3'b111, 1'b1, 24'h000000};
        tbl[1]  = '{1'b1, 3'b111, 24'h332211, 1'b1, 1'b0, 3'b111, 1'b0, 24'h000000};
        tbl[2]  = '{1'b1, 3'b000, 24'h000000, 1'b1, 1'b1, 3'b111, 1'b1, 24'h332211};
        tbl[3]  = '{1'b1, 3'b000, 24'h000000, 1'b1, 1'b0, 3'b111, 1'b0, 24'h000000};
        tbl[4]  = '{1'b1, 3'b111, 24'h665544, 1'b0, 1'b0, 3'b111, 1'b0, 24'h000000};
        tbl[5]  = '{1'b1, 3'b111, 24'hccbbaa, 1'b0, 1'b1, 3'b000, 1'b1, 24'h665544};
        tbl[6]  = '{1'b1, 3'b111, 24'hccbbaa, 1'b0, 1'b1, 3'b000, 1'b1, 24'h665544};
        tbl[7]  = '{1'b1, 3'b111, 24'hccbbaa, 1'b0, 1'b1, 3'b000, 1'b1, 24'h665544};
        tbl[8]  = '{1'b1, 3'b111, 24'hccbbaa, 1'b0, 1'b1, 3'b000, 1'b1, 24'h665544};
        tbl[9]  = '{1'b1, 3'b000, 24'h000000, 1'b1, 1'b1, 3'b111, 1'b1, 24'h665544};
        tbl[10] = '{1'b1, 3'b000, 24'h000000, 1'b1, 1'b0, 3'b111, 1'b0, 24'h000000};
        tbl[11] = '{1'b1, 3'b011, 24'h007788, 1'b1, 1'b0, 3'b111, 1'b0, 24'h000000};
        tbl[12] = '{1'b0, 3'b000, 24'h000000, 1'b1, 1'b0, 3'b000, 1'b0, 24'h000000};
        tbl[13] = '{1'b1, 3'b100, 24'h990000, 1'b1, 1'b0, 3'b111, 1'b1, 24'h000000};
        tbl[14] = '{1'b1, 3'b011, 24'h00bbaa, 1'b1, 1'b0, 3'b011, 1'b0, 24'h000000};
        tbl[15] = '{1'b1, 3'b000, 24'h000000, 1'b1, 1'b1, 3'b111, 1'b1, 24'h99bbaa};
        tbl[16] = '{1'b1, 3'b000, 24'h000000, 1'b1, 1'b0, 3'b111, 1'b0, 24'h000000};

        valid_i = '0;
        data_i  = '0;
        ready_i = 1'b0;
        rst_ni  = 1'b0;
        step('0, '0, 1'b0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0, 1'b0);

        foreach (tbl[k]) begin
            step(tbl[k].v, tbl[k].d, tbl[k].r, tbl[k].rs, 1'b1);
            chk($sformatf("tbl%0d_valid", k), 32'(s_vo), 32'(tbl[k].evo));
            chk($sformatf("tbl%0d_ready", k), 32'(s_ro), 32'(tbl[k].ero));
            if (tbl[k].cd)
                chk($sformatf("tbl%0d_data", k), 32'(s_do), 32'(tbl[k].edo));
        end

        // Skewed arrivals: lanes land at cycles 0, 2 and 5.
        pops = 0;
        for (int c = 0; c < 10; c++) begin
            rv = (c == 0) ? 3'b001 : (c == 2) ? 3'b010 :
                 (c == 5) ? 3'b100 : 3'b000;
            step(rv, 24'h5a4b3c, 1'b1, 1'b1, 1'b1);
            if (c >= 1 && c <= 5) chk("skew_ready0", 32'(s_ro[0]), 32'd0);
            chk("skew_valid", 32'(s_vo), 32'(c == 6));
            if (s_vo) pops++;
        end
        chk("skew_pops", 32'(pops), 32'd1);

        // Streaming: one join per cycle, no gaps, in order.
        for (int k = 0; k < 20; k++) begin
            step(3'b111, {8'(3*k+2), 8'(3*k+1), 8'(3*k)}, 1'b1, 1'b1, 1'b1);
            if (k > 0) begin
                chk("stream_valid", 32'(s_vo), 32'd1);
                chk("stream_data", 32'(s_do),
                    32'({8'(3*k-1), 8'(3*k-2), 8'(3*k-3)}));
            end
        end
        step('0, '0, 1'b1, 1'b1, 1'b1);
        step('0, '0, 1'b1, 1'b1, 1'b1);

        // Random traffic with a hold-stability check under backpressure.
        p_hold = 1'b0;
        p_vo   = 1'b0;
        p_do   = '0;
        for (int k = 0; k < 10000; k++) begin
            rv  = 3'($urandom);
            rr  = ($urandom_range(0, 2) != 0);
            rrs = ($urandom_range(0, 999) != 0);
            step(rv, 24'($urandom), rr, rrs, 1'b1);
            if (p_hold) begin
                chk("hold_valid", 32'(s_vo), 32'(p_vo));
                chk("hold_data", 32'(s_do), 32'(p_do));
            end
            p_hold = s_vo && !rr && rrs;
            p_vo   = s_vo;
            p_do   = s_do;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_join_buf.md
STREAM_JOIN_BUF -- requirements
Module: stream_join_buf

Interface
REQ-001 The block SHALL have parameter N_INP, default 2, meaning the number of input streams to join; legal range is 1..32.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the payload bits per input lane; legal range is 1 or more.
REQ-003 The block SHALL have port clk_i, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, width 1: reset, synchronous and active-low.
REQ-005 The block SHALL have port valid_i, input, width N_INP: per-lane input valid.
REQ-006 The block SHALL have port ready_o, output, width N_INP: per-lane input ready.
REQ-007 The block SHALL have port data_i, input, width N_INP*DATA_WIDTH: lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port valid_o, output, width 1: joined output valid.
REQ-009 The block SHALL have port ready_i, input, width 1: joined output ready.
REQ-010 The block SHALL have port data_o, output, width N_INP*DATA_WIDTH: the joined payload, using the same lane packing as data_i.

Function
REQ-011 The block SHALL hold one slot per lane, each consisting of a full_q flag and a DATA_WIDTH data register.
REQ-012 A lane handshake SHALL occur on lane i when valid_i[i] and ready_o[i] are both 1 at a rising edge; the slot then captures data_i lane i and sets full_q[i]=1.
REQ-013 valid_o SHALL equal the AND of all full_q bits, and SHALL be driven directly from registers with no combinational path from valid_i.
REQ-014 An output handshake (pop) SHALL occur when valid_o and ready_i are both 1; on pop every slot not simultaneously captured SHALL clear its full_q.
REQ-015 ready_o[i] SHALL equal (!full_q[i] OR pop) while rst_ni=1; the only combinational path SHALL be ready_i to ready_o.
REQ-016 On a simultaneous pop and lane-i capture, slot i SHALL load the new data and keep full_q[i]=1, so full throughput (one join per cycle) is sustained.
REQ-017 Latency SHALL be one cycle: a lane captured at edge k is visible on data_o and can contribute to valid_o after edge k.
REQ-018 While valid_o=1 and ready_i=0, data_o and valid_o SHALL remain stable, and no slot SHALL change.
REQ-019 A full lane SHALL hold ready_o[i]=0 until the pop cycle; an early lane therefore waits for the slowest lane.
REQ-020 data_o lane i SHALL always reflect slot i data; its content is don't-care while valid_o=0, but the verification model SHALL compare it only when valid_o=1.
REQ-021 valid_i[i] SHALL NOT be required to stay asserted after a lane handshake, and ready_o SHALL NOT depend on valid_i.
REQ-022 With N_INP=1 the block SHALL behave as a one-entry full-throughput pipeline register.

Reset
REQ-023 While rst_ni=0 at a rising edge, all full_q bits SHALL clear and all data registers SHALL load 0.
REQ-024 While rst_ni=0, ready_o SHALL be forced to all zeros combinationally, so no lane handshake is accepted.
REQ-025 After reset, valid_o SHALL be 0, data_o SHALL be 0, and ready_o SHALL be all ones from the first cycle in which rst_ni=1.
REQ-026 Reset asserted mid-operation SHALL discard any partially or fully joined data without producing an output handshake.

Verification (N_INP=3, DATA_WIDTH=8)
REQ-027 Aligned arrivals: all lanes are valid in one cycle with 0x11, 0x22, 0x33 and ready_i=1 -> the next cycle shows valid_o=1 and data_o=0x332211, and the pop completes in that cycle.
REQ-028 Skewed arrivals: lane0 arrives at cycle 0, lane1 at cycle 2, lane2 at cycle 5 -> ready_o[0]=0 during cycles 1..5, valid_o first rises at cycle 6, and exactly one output transfer occurs.
REQ-029 Backpressure: ready_i=0 for 4 cycles while valid_o=1 -> data_o stays stable, ready_o=3'b000, and after ready_i=1 there is exactly one pop.
REQ-030 Streaming: all lanes are valid every cycle with incrementing data and ready_i=1 -> after the first cycle there is one output per cycle, with no gaps, in order.
REQ-031 Reset mid-operation: 2 of 3 slots are full and rst_ni=0 for one cycle -> valid_o=0 afterward, the stale lane data never appears, and the next join contains only post-reset data.
REQ-032 Random: random valid_i and ready_i over 10k cycles against a per-lane queue scoreboard -> no loss, duplication or reordering, and the stability rule of REQ-018 is never violated.
